// File: rtl/clock_div_sched_pkg.sv
// Shared types and default sizing for the scheduled clock divider.
package clock_div_sched_pkg;

   localparam int unsigned WIDTH       = 16;
   localparam int unsigned DEFAULT_DIV = 12587;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } state_e;

endpackage

// File: rtl/clock_div_sched_if.sv
// Control, divisor-request handshake and divided-clock outputs of clock_div_sched.
interface clock_div_sched_if #(
   parameter int unsigned WIDTH = clock_div_sched_pkg::WIDTH
);
   import clock_div_sched_pkg::*;

   logic             en;
   logic             req0;
   logic             req1;
   logic [WIDTH-1:0] div0;
   logic [WIDTH-1:0] div1;
   logic             ack0;
   logic             ack1;
   logic             clk_out;
   logic             tick;
   logic [WIDTH-1:0] active_div;
   logic             busy;

   modport master (
      output en, req0, req1, div0, div1,
      input  ack0, ack1, clk_out, tick, active_div, busy
   );

   modport slave (
      input  en, req0, req1, div0, div1,
      output ack0, ack1, clk_out, tick, active_div, busy
   );

endinterface

// File: rtl/clock_div_sched_arb.sv
// Two-way fixed-priority grant: requester 0 wins over requester 1.
module clock_div_sched_arb (
   input  logic       allow_i,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_c_o
);

   always_comb begin
      gnt_c_o = 2'b00;
      if (allow_i) begin
         if (req_i[0]) begin
            gnt_c_o = 2'b01;
         end else if (req_i[1]) begin
            gnt_c_o = 2'b10;
         end
      end
   end

endmodule

// File: rtl/clock_div_sched.sv
// Programmable clock divider whose terminal count is changed by two arbitrated
// requesters; changes taken while running are deferred to the next toggle.
module clock_div_sched #(
   parameter int unsigned WIDTH       = clock_div_sched_pkg::WIDTH,
   parameter int unsigned DEFAULT_DIV = clock_div_sched_pkg::DEFAULT_DIV
) (
   input logic              clk_in,
   input logic              rst_n,
   clock_div_sched_if.slave bus
);
   import clock_div_sched_pkg::*;

   localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(DEFAULT_DIV);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] active_q, active_d;
   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic             clk_out_q, clk_out_d;
   logic             tick_q, tick_d;
   logic             ack0_q, ack0_d;
   logic             ack1_q, ack1_d;
   logic             busy_q, busy_d;

   logic [1:0]       gnt_c;
   logic             accept_c;
   logic [WIDTH-1:0] sel_div_c;

   // A requester already being acknowledged is masked so a slow drop of req
   // cannot produce a second acceptance of the same request.
   clock_div_sched_arb u_arb (
      .allow_i (state_q != PEND),
      .req_i   ({bus.req1 & ~ack1_q, bus.req0 & ~ack0_q}),
      .gnt_c_o (gnt_c)
   );

   assign accept_c  = |gnt_c;
   assign sel_div_c = gnt_c[0] ? bus.div0 : bus.div1;

   // Next-state, counter, toggle and divisor scheduling.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      active_d  = active_q;
      shadow_d  = shadow_q;
      clk_out_d = clk_out_q;
      tick_d    = 1'b0;
      ack0_d    = gnt_c[0];
      ack1_d    = gnt_c[1];

      if (accept_c) begin
         shadow_d = sel_div_c;
      end

      unique case (state_q)
         IDLE: begin
            cnt_d     = '0;
            clk_out_d = 1'b0;
            if (accept_c) begin
               active_d = sel_div_c;
            end
            if (bus.en) begin
               state_d = RUN;
            end
         end

         RUN, PEND: begin
            if (!bus.en) begin
               state_d   = IDLE;
               cnt_d     = '0;
               clk_out_d = 1'b0;
               if (state_q == PEND) begin
                  active_d = shadow_q;
               end
               // Stopping and accepting together: nothing is left to defer.
               if (accept_c) begin
                  active_d = sel_div_c;
               end
            end else begin
               if (cnt_q == active_q) begin
                  cnt_d     = '0;
                  clk_out_d = ~clk_out_q;
                  tick_d    = 1'b1;
                  if (state_q == PEND) begin
                     active_d = shadow_q;
                     state_d  = RUN;
                  end
               end else begin
                  cnt_d = cnt_q + WIDTH'(1);
               end
               if (accept_c) begin
                  state_d = PEND;
               end
            end
         end

         default: begin
            state_d   = IDLE;
            cnt_d     = '0;
            clk_out_d = 1'b0;
         end
      endcase

      busy_d = (state_d == PEND);
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         active_q  <= RST_DIV;
         shadow_q  <= RST_DIV;
         clk_out_q <= 1'b0;
         tick_q    <= 1'b0;
         ack0_q    <= 1'b0;
         ack1_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         active_q  <= active_d;
         shadow_q  <= shadow_d;
         clk_out_q <= clk_out_d;
         tick_q    <= tick_d;
         ack0_q    <= ack0_d;
         ack1_q    <= ack1_d;
         busy_q    <= busy_d;
      end
   end

   assign bus.clk_out    = clk_out_q;
   assign bus.tick       = tick_q;
   assign bus.ack0       = ack0_q;
   assign bus.ack1       = ack1_q;
   assign bus.active_div = active_q;
   assign bus.busy       = busy_q;

endmodule

// File: tb/tb_clock_div_sched.sv
// Directed and randomized checks of clock_div_sched against a cycle-level model.
module tb_clock_div_sched;

   localparam int unsigned DEF = 12587;

   logic clk_in = 1'b0;
   logic rst_n;

   always #5 clk_in = ~clk_in;

   clock_div_sched_if bus ();

   clock_div_sched dut (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .bus    (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Model: running/pending flags, cycles elapsed since the last toggle.
   bit m_clk, m_tick, m_ack0, m_ack1, m_pending, m_running;
   int m_active, m_shadow, m_elapsed;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
   endtask

   function automatic logic [31:0] dut_vec();
      return {11'b0, bus.clk_out, bus.tick, bus.ack0, bus.ack1, bus.busy, bus.active_div};
   endfunction

   function automatic logic [31:0] exp_vec();
      return {11'b0, m_clk, m_tick, m_ack0, m_ack1, m_pending, 16'(m_active)};
   endfunction

   task automatic model_reset();
      m_clk = 0; m_tick = 0; m_ack0 = 0; m_ack1 = 0;
      m_pending = 0; m_running = 0;
      m_active = DEF; m_shadow = DEF; m_elapsed = 0;
   endtask

   task automatic model_step();
      int win;
      int wdiv;
      win = -1;
      if (!m_pending) begin
         if (bus.req0 && !m_ack0) win = 0;
         else if (bus.req1 && !m_ack1) win = 1;
      end
      wdiv   = (win == 0) ? int'(bus.div0) : int'(bus.div1);
      m_ack0 = (win == 0);
      m_ack1 = (win == 1);
      m_tick = 0;
      if (!m_running) begin
         m_clk = 0; m_elapsed = 0;
         if (win >= 0) begin m_active = wdiv; m_shadow = wdiv; end
         m_running = bus.en;
      end else if (!bus.en) begin
         m_running = 0; m_clk = 0; m_elapsed = 0;
         if (m_pending) m_active = m_shadow;
         if (win >= 0) begin m_active = wdiv; m_shadow = wdiv; end
         m_pending = 0;
      end else begin
         m_elapsed++;
         if (m_elapsed == m_active + 1) begin
            m_elapsed = 0;
            m_clk     = !m_clk;
            m_tick    = 1;
            if (m_pending) begin m_active = m_shadow; m_pending = 0; end
         end
         if (win >= 0) begin m_shadow = wdiv; m_pending = 1; end
      end
   endtask

   // One clock: model follows the edge, outputs compared on the falling edge,
   // and an acknowledged requester drops its request.
   task automatic step();
      @(posedge clk_in);
      if (rst_n) model_step();
      else model_reset();
      @(negedge clk_in);
      check("cycle", dut_vec(), exp_vec());
      if (m_ack0) bus.req0 = 1'b0;
      if (m_ack1) bus.req1 = 1'b0;
   endtask

   task automatic wait_tick(input int budget, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!bus.tick && n < budget);
      check("tick_seen", 32'(bus.tick), 32'd1);
   endtask

   initial begin
      int n, n1, n2;
      rst_n    = 1'b0;
      bus.en   = 1'b0;
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      bus.div0 = '0;
      bus.div1 = '0;
      model_reset();
      #12;
      check("reset", dut_vec(), 32'(DEF));
      @(negedge clk_in);
      rst_n = 1'b1;

      // Default divisor: first toggle and full period.
      bus.en = 1'b1;
      step();
      wait_tick(13000, n);
      check("first_toggle", 32'(n), 32'd12588);
      check("clk_high", 32'(bus.clk_out), 32'd1);
      wait_tick(13000, n1);
      wait_tick(13000, n2);
      check("period_def", 32'(n1 + n2), 32'd25176);

      // Divisor 3 taken in IDLE.
      bus.en = 1'b0;
      step();
      check("idle_clk", 32'(bus.clk_out), 32'd0);
      bus.req0 = 1'b1; bus.div0 = 16'd3;
      step();
      check("ack0_idle", 32'(bus.ack0), 32'd1);
      check("active3", 32'(bus.active_div), 32'd3);
      bus.en = 1'b1;
      step();
      wait_tick(20, n);
      check("half3_a", 32'(n), 32'd4);
      wait_tick(20, n);
      check("half3_b", 32'(n), 32'd4);

      // Change to 1 while running at counter 1.
      step();
      bus.req0 = 1'b1; bus.div0 = 16'd1;
      step();
      check("ack0_run", 32'(bus.ack0), 32'd1);
      check("busy_rise", 32'(bus.busy), 32'd1);
      wait_tick(20, n);
      check("toggle_old", 32'(n), 32'd2);
      check("busy_fall", 32'(bus.busy), 32'd0);
      check("active1", 32'(bus.active_div), 32'd1);
      wait_tick(20, n);
      check("half1", 32'(n), 32'd2);

      // Simultaneous requests: 0 first, 1 after the pending change lands.
      bus.req0 = 1'b1; bus.div0 = 16'd5;
      bus.req1 = 1'b1; bus.div1 = 16'd2;
      step();
      check("ack_pri", 32'({bus.ack0, bus.ack1}), 32'd2);
      wait_tick(20, n);
      check("active5", 32'(bus.active_div), 32'd5);
      step();
      check("ack1_later", 32'({bus.ack0, bus.ack1}), 32'd1);
      check("busy_1", 32'(bus.busy), 32'd1);
      wait_tick(20, n);
      check("half5_rest", 32'(n), 32'd5);
      check("active2", 32'(bus.active_div), 32'd2);

      // Enable dropped in PEND applies the shadow; divisor 0 toggles every cycle.
      bus.req0 = 1'b1; bus.div0 = 16'd7;
      step();
      check("pend7", 32'(bus.busy), 32'd1);
      bus.en = 1'b0;
      step();
      check("en_drop", 32'({bus.clk_out, bus.tick, bus.busy}), 32'd0);
      check("active7", 32'(bus.active_div), 32'd7);
      bus.req0 = 1'b1; bus.div0 = 16'd0;
      step();
      bus.en = 1'b1;
      step();
      for (int i = 0; i < 4; i++) begin
         step();
         check("div0_tick", 32'(bus.tick), 32'd1);
      end

      // Reset in the middle of PEND.
      bus.req0 = 1'b1; bus.div0 = 16'd9;
      step();
      check("pend9", 32'(bus.busy), 32'd1);
      bus.req1 = 1'b1; bus.div1 = 16'd4;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("rst_mid", dut_vec(), 32'(DEF));
      step();
      step();
      check("rst_noack", 32'({bus.ack0, bus.ack1}), 32'd0);
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      rst_n = 1'b1;
      step();
      check("rst_active", 32'(bus.active_div), 32'(DEF));

      // Randomized traffic, withdrawals, enable changes and resets.
      for (int c = 0; c < 4000; c++) begin
         step();
         if ($urandom_range(0, 199) == 0) bus.en = ~bus.en;
         if (!bus.req0 && $urandom_range(0, 15) == 0) begin
            bus.req0 = 1'b1; bus.div0 = 16'($urandom_range(0, 7));
         end else if (bus.req0 && $urandom_range(0, 31) == 0) begin
            bus.req0 = 1'b0;
         end
         if (!bus.req1 && $urandom_range(0, 15) == 0) begin
            bus.req1 = 1'b1; bus.div1 = 16'($urandom_range(0, 7));
         end else if (bus.req1 && $urandom_range(0, 31) == 0) begin
            bus.req1 = 1'b0;
         end
         if ($urandom_range(0, 999) == 0) begin
            rst_n = 1'b0;
            model_reset();
            #1;
            check("rst_async", dut_vec(), exp_vec());
            step();
            rst_n = 1'b1;
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/clock_div_sched.md
CLOCK_DIV_SCHED -- requirements
Module: clock_div_sched

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning the width of the divisor and counter.
REQ-002 The block SHALL have parameter DEFAULT_DIV, default 12587, meaning the terminal count after reset (half period = DEFAULT_DIV+1 cycles).
REQ-003 The block SHALL have port clk_in  input  1  single clock, all logic on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port en  input  1  run enable for the divider.
REQ-006 The block SHALL have ports req0/req1  input  1  divisor-change request from requester 0/1.
REQ-007 The block SHALL have ports div0/div1  input  WIDTH  requested terminal count, valid while the matching req is high.
REQ-008 The block SHALL have ports ack0/ack1  output  1  one-cycle acceptance pulse to requester 0/1.
REQ-009 The block SHALL have port clk_out  output  1  divided clock, registered.
REQ-010 The block SHALL have port tick  output  1  one-cycle pulse, registered, high in the cycle clk_out has just toggled.
REQ-011 The block SHALL have port active_div  output  WIDTH  terminal count currently in use.
REQ-012 The block SHALL have port busy  output  1  high while an accepted divisor is pending (state PEND).

Function
REQ-013 The state machine SHALL have states IDLE, RUN and PEND.
REQ-014 In IDLE the counter SHALL hold 0 and clk_out SHALL hold 0; en=1 sampled at an edge SHALL give RUN at that edge.
REQ-015 In RUN/PEND, at each edge: counter < active_div -> counter+1; counter == active_div -> counter <= 0, clk_out toggles, tick <= 1.
REQ-016 Half period SHALL be active_div+1 cycles; active_div=0 SHALL toggle clk_out every cycle.
REQ-017 Arbitration SHALL be fixed priority, req0 over req1; at most one ack SHALL be high per cycle.
REQ-018 A request SHALL be accepted only in IDLE or RUN, never in PEND; the loser keeps req high and is served later.
REQ-019 On acceptance, ack SHALL pulse in the cycle after req is sampled, and the winner's div SHALL be captured into a shadow register at that same edge.
REQ-020 If the acceptance happens in IDLE, active_div SHALL take the captured value at the acceptance edge, and the state SHALL stay IDLE, or go to RUN if en=1.
REQ-021 If the acceptance happens in RUN, the state SHALL go to PEND and busy SHALL rise at the same edge.
REQ-022 In PEND, at the terminal-count edge, active_div SHALL take the shadow value together with the toggle, and the state SHALL return to RUN.
REQ-023 A req dropped before its ack SHALL be treated as withdrawn, with no ack and no capture.
REQ-024 If en=0 is sampled in RUN or PEND, at that edge the state SHALL go to IDLE, the counter SHALL clear, clk_out SHALL be forced 0, and tick SHALL stay 0.
REQ-025 If en falls while in PEND, the pending shadow value SHALL be applied to active_div at that edge.
REQ-026 If a terminal count and an acceptance occur on the same edge in RUN, the toggle SHALL use the old active_div and the new value SHALL go pending.
REQ-027 The counter SHALL never exceed active_div, because changes apply only at counter = 0.

Reset
REQ-028 While rst_n=0 the block SHALL be asynchronously in IDLE with counter=0, clk_out=0, tick=0, ack0=ack1=0, busy=0, active_div=DEFAULT_DIV and shadow=DEFAULT_DIV.
REQ-029 A reset asserted mid-operation SHALL drop any pending divisor; the first edge after release SHALL behave as IDLE.

Structure
REQ-030 The package clock_div_sched_pkg SHALL hold the state enum (IDLE, RUN, PEND), WIDTH and DEFAULT_DIV.
REQ-031 The 2-way fixed-priority grant logic SHALL be a sub-module named clock_div_sched_arb.
REQ-032 The counter, the toggle and the state machine SHALL stay in clock_div_sched.

Verification
REQ-033 Reset -> clk_out=0, active_div=12587; after en=1, the first toggle SHALL come 12588 cycles after RUN is entered, and the period SHALL be 25176 cycles.
REQ-034 In IDLE, req0 with div0=3, then en=1 -> ack0 pulse, active_div=3, clk_out period 8 cycles, tick every 4 cycles.
REQ-035 In RUN with div=3, req0 with div0=1 at counter=1 -> busy high, toggle at counter=3, then half period 2, busy low.
REQ-036 req0 and req1 together (div0=5, div1=2) in RUN -> ack0 first and 5 applied; ack1 only after the PEND exit; final active_div=2.
REQ-037 In PEND, en dropped -> clk_out=0, IDLE, shadow applied; then div0=0 and en=1 -> clk_out toggles every cycle.
REQ-038 rst_n pulsed low mid-PEND -> all outputs reset at once, no ack, active_div=12587.
